// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/target inputs and PC outputs of the program-counter stage.
//   master : the datapath / controller side (drives redirects, observes the PC)
//   slave  : the pc_sequencer itself
// Signals:
//   Stall, Branch, BranchOffset, Jump, JumpIndex, JumpReg, JumpRegAddr, Exception  (master -> slave)
//   PCResult, PCAddResult, RedirectPend, AddrErr, FetchCount                       (slave -> master)
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              Stall;
    logic              Branch;
    logic [15:0]       BranchOffset;
    logic              Jump;
    logic [25:0]       JumpIndex;
    logic              JumpReg;
    logic [ADDR_W-1:0] JumpRegAddr;
    logic              Exception;
    logic [ADDR_W-1:0] PCResult;
    logic [ADDR_W-1:0] PCAddResult;
    logic              RedirectPend;
    logic              AddrErr;
    logic [CNT_W-1:0]  FetchCount;

    modport master (
        output Stall, Branch, BranchOffset, Jump, JumpIndex, JumpReg, JumpRegAddr, Exception,
        input  PCResult, PCAddResult, RedirectPend, AddrErr, FetchCount
    );

    modport slave (
        input  Stall, Branch, BranchOffset, Jump, JumpIndex, JumpReg, JumpRegAddr, Exception,
        output PCResult, PCAddResult, RedirectPend, AddrErr, FetchCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage for the 32-bit MIPS datapath.
// Holds the PC, produces PC+INC and selects the next PC among sequential, branch,
// jump, jump-register and exception vector. Redirects raised while stalled are
// parked in a one-entry buffer and applied when the stall drops. A misaligned JR
// target traps to EXC_VEC and pulses AddrErr for one cycle. FetchCount counts
// every edge on which the PC is (re)loaded.
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous, active-high reset
//   bus    pc_sequencer_if.slave (control inputs, PC / status outputs)
// ADDR_W must be >= 29 (jump target keeps PC+INC bits [ADDR_W-1:28]).
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       INC       = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180),
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    pc_sequencer_if.slave     bus
);

    typedef enum logic {
        S_RUN  = 1'b0,   // no redirect parked
        S_PEND = 1'b1    // redirect parked during a stall
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q, err_d;
    logic              adv;

    logic [ADDR_W-1:0] pc_add;
    logic [ADDR_W-1:0] bt;
    logic [ADDR_W-1:0] jt;
    logic [ADDR_W-1:0] sel_tgt;
    logic              redir;
    logic              pend;
    logic              jr_misaligned;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VEC;
            tgt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            if (adv)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Next-state logic: first matching rule wins
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        err_d   = 1'b0;
        adv     = 1'b0;

        if (bus.Exception) begin
            state_d = S_RUN;
            pc_d    = EXC_VEC;
            adv     = 1'b1;
        end else if (jr_misaligned) begin
            state_d = S_RUN;
            pc_d    = EXC_VEC;
            err_d   = 1'b1;
            adv     = 1'b1;
        end else if (bus.Stall) begin
            // Only the first redirect seen during a stall is kept
            if (!pend && redir) begin
                state_d = S_PEND;
                tgt_d   = sel_tgt;
            end
        end else if (pend) begin
            // Parked redirect beats any redirect raised this cycle
            state_d = S_RUN;
            pc_d    = tgt_q;
            adv     = 1'b1;
        end else if (redir) begin
            pc_d = sel_tgt;
            adv  = 1'b1;
        end else begin
            pc_d = pc_add;
            adv  = 1'b1;
        end
    end

    // Output / datapath logic
    always_comb begin
        pend    = (state_q == S_PEND);
        pc_add  = pc_q + ADDR_W'(INC);
        bt      = pc_add + {{(ADDR_W-18){bus.BranchOffset[15]}}, bus.BranchOffset, 2'b00};
        jt      = {pc_add[ADDR_W-1:28], bus.JumpIndex, 2'b00};
        redir   = bus.Branch | bus.Jump | bus.JumpReg;

        if (bus.JumpReg)
            sel_tgt = bus.JumpRegAddr;
        else if (bus.Jump)
            sel_tgt = jt;
        else
            sel_tgt = bt;

        // A misaligned JR is ignored only when it arrives behind an already parked redirect
        jr_misaligned = bus.JumpReg && (bus.JumpRegAddr[1:0] != 2'b00) && (!bus.Stall || !pend);

        bus.PCResult     = pc_q;
        bus.PCAddResult  = pc_add;
        bus.RedirectPend = pend;
        bus.AddrErr      = err_q;
        bus.FetchCount   = cnt_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer (ADDR_W=32, INC=4, EXC_VEC=0x180).
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    pc_sequencer #(
        .ADDR_W(32), .INC(4), .RESET_VEC(32'h0), .EXC_VEC(32'h180), .CNT_W(16)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        pend;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_err;
    logic [15:0] m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0; m_err = 1'b0; m_cnt = 16'h0;
    endtask

    // Drive one cycle of inputs, predict the post-edge state, compare after the edge
    task automatic step(input logic st, input logic br, input logic [15:0] off,
                        input logic j, input logic [25:0] idx,
                        input logic jr, input logic [31:0] rta, input logic exc);
        logic [31:0] pa, btv, jtv, sel;
        logic        r;
        exp_t        e;
        bus.Stall = st; bus.Branch = br; bus.BranchOffset = off; bus.Jump = j;
        bus.JumpIndex = idx; bus.JumpReg = jr; bus.JumpRegAddr = rta; bus.Exception = exc;
        #1;
        pa  = m_pc + 32'd4;
        check_eq("pcadd", {32'h0, bus.PCAddResult}, {32'h0, pa});
        btv = pa + {{14{off[15]}}, off, 2'b00};
        jtv = {pa[31:28], idx, 2'b00};
        sel = jr ? rta : (j ? jtv : btv);
        r   = br | j | jr;
        m_err = 1'b0;
        if (exc) begin
            m_pc = 32'h180; m_pend = 1'b0; m_cnt++;
        end else if (jr && rta[1:0] != 2'b00 && (!st || !m_pend)) begin
            m_pc = 32'h180; m_pend = 1'b0; m_err = 1'b1; m_cnt++;
        end else if (st && !m_pend && r) begin
            m_pend = 1'b1; m_tgt = sel;
        end else if (st) begin
            // hold
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0; m_cnt++;
        end else if (r) begin
            m_pc = sel; m_cnt++;
        end else begin
            m_pc = pa; m_cnt++;
        end
        sb.push_back('{pc: m_pc, pend: m_pend, err: m_err, cnt: m_cnt});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_eq("pc",   {32'h0, bus.PCResult},     {32'h0, e.pc});
            check_eq("pend", {63'h0, bus.RedirectPend}, {63'h0, e.pend});
            check_eq("err",  {63'h0, bus.AddrErr},      {63'h0, e.err});
            check_eq("cnt",  {48'h0, bus.FetchCount},   {48'h0, e.cnt});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jr_to(input logic [31:0] a);
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, a, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.Stall = 1'b0; bus.Branch = 1'b0; bus.BranchOffset = '0; bus.Jump = 1'b0;
        bus.JumpIndex = '0; bus.JumpReg = 1'b0; bus.JumpRegAddr = '0; bus.Exception = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pc",   {32'h0, bus.PCResult},     64'h0);
        check_eq("rst_pend", {63'h0, bus.RedirectPend}, 64'h0);
        check_eq("rst_err",  {63'h0, bus.AddrErr},      64'h0);
        check_eq("rst_cnt",  {48'h0, bus.FetchCount},   64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch from RESET_VEC
        repeat (4) idle();
        check_eq("t1_pc", {32'h0, bus.PCResult}, 64'h10);
        check_eq("t1_cnt", {48'h0, bus.FetchCount}, 64'd4);

        // Branch backward / forward from 0x100
        jr_to(32'h100);
        step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        check_eq("t2_bneg", {32'h0, bus.PCResult}, 64'hFC);
        jr_to(32'h100);
        step(1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        check_eq("t2_bpos", {32'h0, bus.PCResult}, 64'h110);

        // Jump keeps upper PC bits; misaligned JR traps
        jr_to(32'h1000_0040);
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0, 1'b0);
        check_eq("t3_j", {32'h0, bus.PCResult}, 64'h1000_0040);
        jr_to(32'h2002);
        check_eq("t3_trap_pc", {32'h0, bus.PCResult}, 64'h180);
        check_eq("t3_adderr1", {63'h0, bus.AddrErr}, 64'h1);
        idle();
        check_eq("t3_adderr0", {63'h0, bus.AddrErr}, 64'h0);

        // Redirect during stall: first one wins, applied when stall drops
        jr_to(32'h200);
        step(1'b1, 1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0, 1'b0);
        check_eq("t4_hold", {32'h0, bus.PCResult}, 64'h200);
        check_eq("t4_pend", {63'h0, bus.RedirectPend}, 64'h1);
        step(1'b1, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        check_eq("t4_hold3", {32'h0, bus.PCResult}, 64'h200);
        step(1'b0, 1'b1, 16'h0020, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        check_eq("t4_go", {32'h0, bus.PCResult}, 64'h100);
        check_eq("t4_pend0", {63'h0, bus.RedirectPend}, 64'h0);

        // Exception overrides stall and clears pending
        step(1'b1, 1'b0, 16'h0, 1'b1, 26'h55, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
        check_eq("t5_exc", {32'h0, bus.PCResult}, 64'h180);
        check_eq("t5_pend0", {63'h0, bus.RedirectPend}, 64'h0);

        // Misaligned JR while stalled without pending traps
        step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h301, 1'b0);
        check_eq("t5b_trap", {63'h0, bus.AddrErr}, 64'h1);

        // Wrap and async reset mid-stall with pending
        jr_to(32'hFFFF_FFFC);
        idle();
        check_eq("t6_wrap", {32'h0, bus.PCResult}, 64'h0);
        step(1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rpc",   {32'h0, bus.PCResult},     64'h0);
        check_eq("t6_rpend", {63'h0, bus.RedirectPend}, 64'h0);
        check_eq("t6_rcnt",  {48'h0, bus.FetchCount},   64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.Stall = 1'b0; bus.Branch = 1'b0;
        repeat (2) idle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, 16'($urandom),
                 $urandom_range(0, 5) == 0, 26'($urandom),
                 $urandom_range(0, 6) == 0, a, $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
